// File: rtl/msg_scroll_ctrl.sv
// msg_scroll_ctrl: debounced pushbutton / timed auto-advance scroller over a 14-entry segment message ROM
// IDLE -> SHOW idx 0..13 -> GAP (blank) -> SHOW idx 0 ...; outputs are registered.
module msg_scroll_ctrl #(
    parameter int DB_CYCLES = 1000,
    parameter int TICK_BASE = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       auto_en,
    input  logic       pause,
    input  logic [1:0] rate,
    input  logic       clr,
    output logic [7:0] seg_out,
    output logic [3:0] idx,
    output logic       wrap
);
    localparam int DW = $clog2(DB_CYCLES) + 1;
    localparam int CW = $clog2(TICK_BASE) + 4;

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t          state, state_n;
    logic            s0, s1, acc, acc_q;
    logic [DW-1:0]   db_cnt;
    logic [CW-1:0]   auto_cnt, period_m1;
    logic [1:0]      rate_q;
    logic            btn_step, auto_tick, step, rate_chg;
    logic [3:0]      idx_n;
    logic [7:0]      seg_n;
    logic            wrap_n;

    function automatic logic [7:0] rom(input logic [3:0] i);
        case (i)
            4'd0:  rom = 8'h80;
            4'd1:  rom = 8'h5B;
            4'd2:  rom = 8'h4F;
            4'd3:  rom = 8'h15;
            4'd4:  rom = 8'h7E;
            4'd5:  rom = 8'h0E;
            4'd6:  rom = 8'h5F;
            4'd7:  rom = 8'h3E;
            4'd8:  rom = 8'h0E;
            4'd9:  rom = 8'h5F;
            4'd10: rom = 8'h7E;
            4'd11: rom = 8'h15;
            4'd12: rom = 8'h3E;
            4'd13: rom = 8'h0E;
            default: rom = 8'h00;
        endcase
    endfunction

    // two-flop synchronizer feeding a hold-for-DB_CYCLES debouncer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {s0, s1, acc, acc_q} <= '0;
            db_cnt <= '0;
        end else begin
            s0    <= btn;
            s1    <= s0;
            acc_q <= acc;
            if (s1 == acc)
                db_cnt <= '0;
            else if (db_cnt == DW'(DB_CYCLES - 1)) begin
                acc    <= s1;
                db_cnt <= '0;
            end else
                db_cnt <= db_cnt + DW'(1);
        end
    end

    assign btn_step  = acc & ~acc_q;
    assign period_m1 = (CW'(TICK_BASE) << rate) - CW'(1);
    assign rate_chg  = rate != rate_q;
    // a freshly changed rate restarts the period instead of ticking against the new limit
    assign auto_tick = auto_en & ~pause & ~rate_chg & (auto_cnt == period_m1);
    assign step      = btn_step | auto_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt <= '0;
            rate_q   <= '0;
        end else begin
            rate_q   <= rate;
            auto_cnt <= (clr | ~auto_en | rate_chg | step) ? '0 :
                        pause ? auto_cnt : auto_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            seg_out <= '0;
            wrap    <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            seg_out <= seg_n;
            wrap    <= wrap_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        if (clr) begin
            state_n = IDLE;
            idx_n   = '0;
        end else if (step) begin
            state_n = (state == SHOW && idx == 4'd13) ? GAP : SHOW;
            idx_n   = (state == SHOW) ? ((idx == 4'd13) ? idx : idx + 4'd1) : 4'd0;
        end
    end

    always_comb begin
        seg_n  = (state_n == SHOW) ? rom(idx_n) : 8'h00;
        wrap_n = (state_n == GAP) && (state != GAP);
    end
endmodule

// File: tb/tb_msg_scroll_ctrl.sv
// tb_msg_scroll_ctrl: random + directed stimulus checked every cycle against a position-based model
module tb_msg_scroll_ctrl;
    logic       clk = 0, rst_n = 0, btn = 0, auto_en = 0, pause = 0, clr = 0;
    logic [1:0] rate = 0;
    logic [7:0] seg_out;
    logic [3:0] idx;
    logic       wrap;

    int errors = 0, checks = 0;
    bit chk_en = 0;

    localparam logic [7:0] MSG [14] = '{8'h80, 8'h5B, 8'h4F, 8'h15, 8'h7E, 8'h0E, 8'h5F,
                                        8'h3E, 8'h0E, 8'h5F, 8'h7E, 8'h15, 8'h3E, 8'h0E};

    msg_scroll_ctrl #(.DB_CYCLES(4), .TICK_BASE(8)) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .auto_en(auto_en), .pause(pause),
        .rate(rate), .clr(clr), .seg_out(seg_out), .idx(idx), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: scroll position -1 = idle, 0..13 = showing that entry, 14 = blank gap
    bit m_s0, m_s1, m_acc, m_accp, m_wrap;
    int m_run, m_cnt, m_prate, m_pos = -1;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            {m_s0, m_s1, m_acc, m_accp, m_wrap} = '0;
            m_run = 0; m_cnt = 0; m_prate = 0; m_pos = -1;
        end else begin
            automatic bit tick = auto_en && !pause && int'(rate) == m_prate && m_cnt == (8 << rate) - 1;
            automatic bit stp  = (m_acc && !m_accp) || tick;
            m_wrap = 0;
            if (clr) m_pos = -1;
            else if (stp) begin
                m_pos  = (m_pos + 1) % 15;
                m_wrap = m_pos == 14;
            end
            m_cnt   = (clr || !auto_en || int'(rate) != m_prate || stp) ? 0 : pause ? m_cnt : m_cnt + 1;
            m_prate = int'(rate);
            m_accp  = m_acc;
            if (m_s1 != m_acc) begin
                m_run++;
                if (m_run == 4) begin m_acc = m_s1; m_run = 0; end
            end else m_run = 0;
            m_s1 = m_s0;
            m_s0 = btn;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("seg_out", seg_out, (m_pos >= 0 && m_pos < 14) ? MSG[m_pos] : 0);
            chk("idx", idx, m_pos < 0 ? 0 : (m_pos == 14 ? 13 : m_pos));
            chk("wrap", wrap, m_wrap);
        end
    end

    initial begin
        int n, nw, pre;
        logic [7:0] prev;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_seg", seg_out, 0);
        chk("reset_idx", idx, 0);
        chk("reset_wrap", wrap, 0);
        rst_n = 1; chk_en = 1;
        repeat (100) @(negedge clk);
        chk("idle_hold", seg_out, 0);

        btn = 1;
        repeat (6) @(negedge clk);
        chk("btn_lat6", seg_out, 8'h00);
        @(negedge clk);
        chk("btn_lat7", seg_out, 8'h80);
        chk("btn_idx", idx, 0);
        repeat (5) @(negedge clk);
        btn = 0;
        repeat (20) @(negedge clk);
        chk("no_release_step", seg_out, 8'h80);

        clr = 1; @(negedge clk); clr = 0;
        for (int i = 0; i < 20; i++) begin btn = ~btn; repeat (2) @(negedge clk); end
        btn = 0;
        repeat (20) @(negedge clk);
        chk("bounce_reject", seg_out, 0);

        clr = 1; @(negedge clk); clr = 0; auto_en = 1; rate = 0;
        nw = 0;
        for (int i = 0; i < 130; i++) begin @(negedge clk); if (wrap) nw++; end
        chk("auto_wraps", nw, 1);
        chk("auto_restart_seg", seg_out, 8'h80);
        chk("auto_restart_idx", idx, 0);

        clr = 1; rate = 2; @(negedge clk); clr = 0;
        prev = seg_out; n = 0;
        while (seg_out == prev && n < 100) begin @(negedge clk); n++; end
        chk("rate2_first", n, 32);
        repeat (10) @(negedge clk);
        pause = 1;
        repeat (20) @(negedge clk);
        pause = 0;
        prev = seg_out; n = 0;
        while (seg_out == prev && n < 100) begin @(negedge clk); n++; end
        chk("pause_resume", n, 22);
        pre = idx;
        repeat (25) @(negedge clk);
        btn = 1;
        repeat (7) @(negedge clk);
        chk("coincident_step", idx, pre + 1);
        btn = 0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 3) btn = ~btn;
            if ($urandom_range(0, 99) < 2) auto_en = ~auto_en;
            if ($urandom_range(0, 99) < 5) pause = ~pause;
            if ($urandom_range(0, 99) < 1) rate = 2'($urandom_range(0, 3));
            clr = $urandom_range(0, 199) == 0;
        end

        clr = 1; btn = 0; pause = 0; auto_en = 1; rate = 0;
        @(negedge clk); clr = 0;
        n = 0;
        while (idx != 7 && n < 300) begin @(negedge clk); n++; end
        chk("pre_rst_seg", seg_out, 8'h3E);
        #2 rst_n = 0;
        #1;
        chk("async_rst_seg", seg_out, 0);
        chk("async_rst_idx", idx, 0);
        chk("async_rst_wrap", wrap, 0);
        @(negedge clk); rst_n = 1;
        n = 0;
        while (idx != 5 && n < 300) begin @(negedge clk); n++; end
        chk("pre_clr_seg", seg_out, 8'h0E);
        clr = 1;
        @(negedge clk);
        chk("clr_seg", seg_out, 0);
        chk("clr_idx", idx, 0);
        clr = 0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
